// File: rtl/mips_pkg.sv
// Shared fetch-path constants and the fetch-entry field layout {pc4, instr}.
// Has no latency and no flow control of its own.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc4;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fq_storage.sv
// DEPTH-entry register file: one synchronous write port, one asynchronous read port.
// Writes land at the clock edge and reads are combinational; the caller owns pointers and flow control.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdat,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdat
);
  logic [W-1:0] r_mem [DEPTH];

  // Contents are qualified by the owner's count, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdat;
  end

  assign o_rdat = r_mem[i_raddr];
endmodule

// File: rtl/fetch_queue.sv
// Prefetch queue between fetch and ID: a word fetched at edge N is presented to ID after that edge.
// Holds the PC (pc_write=0) only while full and not flushing; flush drops all queued and in-flight words.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = ADDR_W,
  parameter int IW    = INSTR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AW-1:0]              fetch_pc,
  input  logic [IW-1:0]              fetch_instr,
  output logic                       pc_write,
  input  logic                       flush,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [IW-1:0]              id_instr,
  output logic [AW-1:0]              id_pc4,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_enq;
  logic             w_deq;
  logic [AW+IW-1:0] w_wdat;
  logic [AW+IW-1:0] w_rdat;

  assign w_full   = (r_count == FULL_CNT);
  assign w_enq    = ~w_full & ~flush;
  assign w_deq    = id_valid & id_ready & ~flush;
  assign pc_write = flush | ~w_full;
  assign w_wdat   = {fetch_pc + AW'(4), fetch_instr};

  fq_storage #(.DEPTH(DEPTH), .W(AW + IW)) u_storage (
    .clk     (clk),
    .i_we    (w_enq),
    .i_waddr (r_wr_ptr),
    .i_wdat  (w_wdat),
    .i_raddr (r_rd_ptr),
    .o_rdat  (w_rdat)
  );

  // Flush outranks enq/deq: the word fetched in the flush cycle is wrong-path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_enq && !w_deq)      r_count <= r_count + CW'(1);
      else if (w_deq && !w_enq) r_count <= r_count - CW'(1);
    end
  end

  assign count    = r_count;
  assign id_valid = (r_count != '0);
  assign id_instr = id_valid ? w_rdat[IW-1:0]     : NOP_INSTR[IW-1:0];
  assign id_pc4   = id_valid ? w_rdat[AW+IW-1:IW] : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: reset, fill/stall, order across wrap, flush, simultaneous enq/deq.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        pc_write;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(4), .AW(32), .IW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .pc_write    (pc_write),
    .flush       (flush),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc4      (id_pc4),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] pc);
    fetch_pc    = pc;
    fetch_instr = instr_of(pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
    fetch(32'h0);
    #1;
    check("rst_valid", id_valid, 0);
    check("rst_count", count, 0);
    check("rst_pcwr", pc_write, 1);
    check("rst_instr", id_instr, 0);
    check("rst_pc4", id_pc4, 0);
    step();
    check("rst_hold_count", count, 0);
    rst = 1'b0;

    // Fill with ID stalled
    fetch(32'h00); #1;
    check("fill_pre_count", count, 0);
    step();
    check("fill1_count", count, 1);
    check("fill1_valid", id_valid, 1);
    check("fill1_pc4", id_pc4, 32'h04);
    check("fill1_instr", id_instr, instr_of(32'h00));
    fetch(32'h04); step();
    check("fill2_count", count, 2);
    check("fill2_pc4", id_pc4, 32'h04);
    fetch(32'h08); step();
    check("fill3_count", count, 3);
    check("fill3_pcwr", pc_write, 1);
    fetch(32'h0C); step();
    check("fill4_count", count, 4);
    check("fill4_pcwr", pc_write, 0);
    check("fill4_pc4", id_pc4, 32'h04);
    fetch(32'h10); step();
    check("full_hold_count", count, 4);
    check("full_hold_pc4", id_pc4, 32'h04);
    check("full_hold_instr", id_instr, instr_of(32'h00));

    // Flush while full
    flush = 1'b1; #1;
    check("flushfull_pcwr", pc_write, 1);
    step();
    flush = 1'b0;
    check("flushfull_count", count, 0);
    check("flushfull_valid", id_valid, 0);
    check("flushfull_instr", id_instr, 0);
    check("flushfull_pc4", id_pc4, 0);
    fetch(32'h200); step();
    check("target_count", count, 1);
    check("target_pc4", id_pc4, 32'h204);

    // Flush with id_ready=1 and count=1
    id_ready = 1'b1; flush = 1'b1; fetch(32'h300); step();
    flush = 1'b0; id_ready = 1'b0;
    check("flush1_count", count, 0);
    check("flush1_valid", id_valid, 0);

    // Simultaneous enq/deq at count=2
    fetch(32'h400); step();
    fetch(32'h404); step();
    check("sim_pre_count", count, 2);
    check("sim_pre_pc4", id_pc4, 32'h404);
    id_ready = 1'b1; fetch(32'h408); step();
    check("sim_count", count, 2);
    check("sim_pc4", id_pc4, 32'h408);
    check("sim_instr", id_instr, instr_of(32'h404));

    // Order across pointer wrap with ID always ready
    id_ready = 1'b0; flush = 1'b1; step();
    flush = 1'b0; id_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      fetch(32'h100 + 32'(4 * k));
      step();
      check($sformatf("wrap%0d_pc4", k), id_pc4, 32'h104 + 32'(4 * k));
      check($sformatf("wrap%0d_instr", k), id_instr, instr_of(32'h100 + 32'(4 * k)));
      check($sformatf("wrap%0d_count", k), count, 1);
    end

    // Async reset mid-stream with count=3
    id_ready = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    fetch(32'h500); step();
    fetch(32'h504); step();
    fetch(32'h508); step();
    check("pre_rst_count", count, 3);
    #2 rst = 1'b1; #1;
    check("midrst_valid", id_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_pcwr", pc_write, 1);
    fetch(32'h600); step();
    check("rst_edge_count", count, 0);
    #2 rst = 1'b0;
    step();
    check("post_rst_count", count, 1);
    check("post_rst_pc4", id_pc4, 32'h604);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
